net_endpoint_adapter: RTL
=========================

Name: net_endpoint_adapter

Overview:
Terminal-side network interface that sits at the terminal port (port 1) of one ring router. It is the injecting and ejecting end of the router's 44-bit message protocol.
- TX path: converts client send requests (dest + 32-bit data) into network messages, stamping src and a per-destination sequence number in the opaque field.
- RX path: buffers messages ejected by the router, strips the header for the client, and checks per-source sequence ordering.

Parameters:
p_msg_nbits, 44, network message width; fixed field layout: dest [43:42], src [41:40], opaque [39:32], payload [31:0]
p_nrouters, 4, routers on the ring; sets the number of per-node sequence counters
p_rxq_nentries, 2, RX buffer depth

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
router_id  input  2  id of the attached router; used as src on TX
send_dest  input  2  destination router id
send_data  input  32  payload to send
send_val  input  1  send request valid
send_rdy  output  1  adapter can accept a send
net_ostream_msg  output  44  message to router istream[1]
net_ostream_val  output  1  valid toward router
net_ostream_rdy  input  1  router ready
net_istream_msg  input  44  message from router ostream[1]
net_istream_val  input  1  valid from router
net_istream_rdy  output  1  adapter can accept from router
recv_src  output  2  source router of delivered message
recv_seq  output  8  opaque/sequence field of delivered message
recv_data  output  32  payload of delivered message
recv_val  output  1  delivered message valid
recv_rdy  input  1  client ready
seq_err  output  1  sticky out-of-order detection flag
seq_err_src  output  2  source of the first mismatch

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high (reset), sampled on the rising edge of clk. Handshakes use val/rdy; a transfer occurs when val && rdy at a rising edge.
- Reset values: net_ostream_val=0, recv_val=0, seq_err=0, seq_err_src=0, all tx_seq[] and rx_expect[] counters=0, RX buffer empty. Reset asserted mid-transfer drops any buffered TX/RX message; nothing is delivered after reset.
- TX path: 2-entry skid buffer.
  - send_rdy = buffer not full; it depends only on registered state, never on net_ostream_rdy combinationally.
  - On a send transfer, the enqueued message is {send_dest, router_id, tx_seq[send_dest], send_data}, then tx_seq[send_dest] increments. The counter is 8-bit and wraps 255->0.
  - Latency: a message accepted in cycle N is valid on net_ostream in cycle N+1.
  - Throughput: 1 message/cycle while the router is ready.
  - net_ostream_msg is stable while val && !rdy.
  - dest==router_id is legal; the message is sent unchanged and the router loops it back.
- RX path: normal queue of depth p_rxq_nentries, no bypass.
  - net_istream_rdy = !full; depends only on state.
  - Enqueue and dequeue in the same cycle are both honoured when the queue is neither empty nor full.
  - When the queue is full, net_istream_rdy=0, so enqueue is blocked even if a dequeue occurs that cycle.
  - Latency: message accepted at cycle N appears on recv_* at N+1.
  - recv_src=msg[41:40], recv_seq=msg[39:32], recv_data=msg[31:0]. The dest field is not checked.
- Sequence check: performed at RX enqueue.
  - Match (opaque == rx_expect[src]): no error.
  - Mismatch: if seq_err==0, set seq_err=1 and capture seq_err_src=src. seq_err is sticky until reset; later mismatches do not overwrite seq_err_src.
  - In either case, rx_expect[src] = opaque+1 (mod 256), so the checker resynchronises. The message is still delivered.
- No state machine beyond queue full/empty pointers. Counters are independent per node index; a send and a receive in the same cycle touch disjoint state.

Decomposition:
- Shared package net_endpoint_pkg:
  - field position localparams (DEST_MSB/LSB, SRC, OPAQUE, PAYLOAD)
  - packed struct net_msg_t {dest, src, opaque, payload}
  - SEQ_NBITS=8
- One natural sub-module: net_endpoint_seq_table, a p_nrouters x 8-bit counter array with read-index, increment-enable, and load ports. It is instantiated twice: once for tx_seq, once for rx_expect.
- Queues reuse the existing library normal queue.

Test Plan:
- Reset, then router_id=2, send (dest=0, data=0xDEADBEEF) with net_ostream_rdy=1 -> next cycle net_ostream_msg = {0,2,0x00,0xDEADBEEF}, val=1; a second send to dest 0 carries opaque 0x01.
- 257 sends to dest=3 with the router always ready -> opaque runs 0..255 then 0; tx_seq[0..2] untouched; exactly one message per cycle.
- Backpressure: hold net_ostream_rdy=0 and drive 3 sends -> 2 accepted, send_rdy=0 thereafter, msg held stable; release rdy -> messages emerge in order, one per cycle.
- RX in-order: inject src=1 with opaque 0,1,2 and recv_rdy=1 -> recv_* deliver each one cycle later with seq 0,1,2; seq_err stays 0.
- RX gap: inject src=3 with opaque 0 then 2, then src=0 with opaque 5 -> seq_err=1 after the second message, seq_err_src=3, unchanged after the src-0 mismatch; all three messages delivered.
- RX full plus reset mid-operation: recv_rdy=0, inject 3 messages -> net_istream_rdy=0 after 2; assert reset one cycle -> recv_val=0, net_istream_rdy=1, counters 0, seq_err=0.

Source files
------------

// File: rtl/net_endpoint_pkg.sv
// Shared types and field layout for the ring network endpoint.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package net_endpoint_pkg;

    localparam int MSG_NBITS     = 44;
    localparam int NODE_NBITS    = 2;
    localparam int SEQ_NBITS     = 8;
    localparam int PAYLOAD_NBITS = 32;

    localparam int DEST_MSB    = 43;
    localparam int DEST_LSB    = 42;
    localparam int SRC_MSB     = 41;
    localparam int SRC_LSB     = 40;
    localparam int OPAQUE_MSB  = 39;
    localparam int OPAQUE_LSB  = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    typedef logic [NODE_NBITS-1:0]    node_id_t;
    typedef logic [SEQ_NBITS-1:0]     seq_t;
    typedef logic [PAYLOAD_NBITS-1:0] payload_t;

    // Field order matches the bit positions above (dest in the MSBs).
    typedef struct packed {
        node_id_t dest;
        node_id_t src;
        seq_t     opaque;
        payload_t payload;
    } net_msg_t;

    // Sequence numbers wrap 255 -> 0.
    function automatic seq_t seq_next(input seq_t s);
        return s + SEQ_NBITS'(1);
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic normal (non-bypass) queue with valid/ready on both sides.
// Latency: an entry enqueued at edge N is visible on deq_dat after edge N (cycle N+1).
// Backpressure: enq_rdy = !full from registered state only; a full queue blocks enqueue even while dequeuing.
module fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_vld,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_dat,
    output logic               deq_vld,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_dat
);

    localparam int AW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth + 1);

    logic [p_width-1:0] mem_q [p_depth];
    logic [p_width-1:0] mem_d [p_depth];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               enq_xfer;
    logic               deq_xfer;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(p_depth - 1)) ? '0 : p + AW'(1);
    endfunction

    assign enq_rdy  = (count_q != CW'(p_depth));
    assign deq_vld  = (count_q != '0);
    assign deq_dat  = mem_q[rd_ptr_q];
    assign enq_xfer = enq_vld && enq_rdy;
    assign deq_xfer = deq_vld && deq_rdy;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_xfer) begin
            mem_d[wr_ptr_q] = enq_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (deq_xfer) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (enq_xfer && !deq_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!enq_xfer && deq_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/net_endpoint_seq_table.sv
// Per-node 8-bit sequence counter array with one indexed read/modify port.
// Latency: rd_cnt is combinational from state; increment/load take effect at the next edge.
// Backpressure: none; the caller gates inc_en/ld_en with its own transfer condition.
module net_endpoint_seq_table
    import net_endpoint_pkg::*;
#(
    parameter int p_nentries  = 4,
    parameter int p_idx_nbits = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_idx_nbits-1:0] rd_idx,
    output seq_t                   rd_cnt,
    input  logic                   inc_en,
    input  logic                   ld_en,
    input  seq_t                   ld_cnt
);

    seq_t cnt_q [p_nentries];
    seq_t cnt_d [p_nentries];

    assign rd_cnt = cnt_q[rd_idx];

    // Only the indexed entry changes; a load wins over an increment.
    always_comb begin
        cnt_d = cnt_q;
        if (ld_en) begin
            cnt_d[rd_idx] = ld_cnt;
        end else if (inc_en) begin
            cnt_d[rd_idx] = seq_next(cnt_q[rd_idx]);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_nentries; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/net_endpoint_adapter.sv
// Terminal-port endpoint: injects client sends as stamped network messages and ejects received ones with an order check.
// Latency: send accepted in cycle N is on net_ostream in N+1; router message accepted in N is on recv_* in N+1.
// Backpressure: send_rdy / net_istream_rdy are !full of 2-entry queues, from registered state only.
module net_endpoint_adapter
    import net_endpoint_pkg::*;
#(
    parameter int p_msg_nbits    = 44,
    parameter int p_nrouters     = 4,
    parameter int p_rxq_nentries = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             router_id,
    input  logic [1:0]             send_dest,
    input  logic [31:0]            send_data,
    input  logic                   send_val,
    output logic                   send_rdy,
    output logic [p_msg_nbits-1:0] net_ostream_msg,
    output logic                   net_ostream_val,
    input  logic                   net_ostream_rdy,
    input  logic [p_msg_nbits-1:0] net_istream_msg,
    input  logic                   net_istream_val,
    output logic                   net_istream_rdy,
    output logic [1:0]             recv_src,
    output logic [7:0]             recv_seq,
    output logic [31:0]            recv_data,
    output logic                   recv_val,
    input  logic                   recv_rdy,
    output logic                   seq_err,
    output logic [1:0]             seq_err_src
);

    localparam int TXQ_NENTRIES = 2;

    // ---------------- TX path ----------------
    seq_t     tx_seq_cnt;
    logic     send_xfer;
    net_msg_t tx_msg;

    assign send_xfer = send_val && send_rdy;
    assign tx_msg    = '{dest: send_dest, src: router_id, opaque: tx_seq_cnt, payload: send_data};

    net_endpoint_seq_table #(
        .p_nentries  (p_nrouters),
        .p_idx_nbits (NODE_NBITS)
    ) u_tx_seq (
        .clk    (clk),
        .reset  (reset),
        .rd_idx (send_dest),
        .rd_cnt (tx_seq_cnt),
        .inc_en (send_xfer),
        .ld_en  (1'b0),
        .ld_cnt ('0)
    );

    fifo #(
        .p_width (p_msg_nbits),
        .p_depth (TXQ_NENTRIES)
    ) u_txq (
        .clk     (clk),
        .reset   (reset),
        .enq_vld (send_val),
        .enq_rdy (send_rdy),
        .enq_dat (tx_msg),
        .deq_vld (net_ostream_val),
        .deq_rdy (net_ostream_rdy),
        .deq_dat (net_ostream_msg)
    );

    // ---------------- RX path ----------------
    net_msg_t               rx_in;
    net_msg_t               rx_out;
    logic [p_msg_nbits-1:0] rx_out_dat;
    logic                   rx_xfer;
    seq_t                   rx_exp_cnt;
    logic                   seq_mismatch;
    logic                   seq_err_q, seq_err_d;
    node_id_t               seq_err_src_q, seq_err_src_d;

    assign rx_in   = net_msg_t'(net_istream_msg);
    assign rx_xfer = net_istream_val && net_istream_rdy;

    // The checker always resynchronises to the opaque value it just saw.
    net_endpoint_seq_table #(
        .p_nentries  (p_nrouters),
        .p_idx_nbits (NODE_NBITS)
    ) u_rx_expect (
        .clk    (clk),
        .reset  (reset),
        .rd_idx (rx_in.src),
        .rd_cnt (rx_exp_cnt),
        .inc_en (1'b0),
        .ld_en  (rx_xfer),
        .ld_cnt (seq_next(rx_in.opaque))
    );

    fifo #(
        .p_width (p_msg_nbits),
        .p_depth (p_rxq_nentries)
    ) u_rxq (
        .clk     (clk),
        .reset   (reset),
        .enq_vld (net_istream_val),
        .enq_rdy (net_istream_rdy),
        .enq_dat (net_istream_msg),
        .deq_vld (recv_val),
        .deq_rdy (recv_rdy),
        .deq_dat (rx_out_dat)
    );

    assign rx_out    = net_msg_t'(rx_out_dat);
    assign recv_src  = rx_out.src;
    assign recv_seq  = rx_out.opaque;
    assign recv_data = rx_out.payload;

    // Sticky error flag; only the first mismatching source is recorded.
    always_comb begin
        seq_err_d     = seq_err_q;
        seq_err_src_d = seq_err_src_q;
        seq_mismatch  = rx_xfer && (rx_in.opaque != rx_exp_cnt);
        if (seq_mismatch && !seq_err_q) begin
            seq_err_d     = 1'b1;
            seq_err_src_d = rx_in.src;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_err_q     <= 1'b0;
            seq_err_src_q <= '0;
        end else begin
            seq_err_q     <= seq_err_d;
            seq_err_src_q <= seq_err_src_d;
        end
    end

    assign seq_err     = seq_err_q;
    assign seq_err_src = seq_err_src_q;

endmodule
